// File: rtl/stack_arbiter.sv
// stack_arbiter
// Shares one B-bit, L-deep LIFO stack between N requesters. Requests are
// granted round-robin, one push or pop at a time. The block drives
// single-cycle push/pop/clear strobes to the stack and keeps its own
// occupancy count so the stack is never overflowed or underflowed.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req[N], op[N]       request level and operation (0=push, 1=pop)
//   wdata[N*B]          push data, requester i at [i*B +: B]
//   flush               level request to empty the stack (served in IDLE)
//   ack[N], err         one-cycle completion pulse; err=1 marks a reject
//   rdata[B]            last successfully popped word
//   st_push/st_pop/st_clr, st_wdata, st_rdata   stack-side interface
//   count, full, empty  occupancy; busy = FSM not idle
module stack_arbiter #(
  parameter int B = 13,
  parameter int L = 8,
  parameter int N = 2,
  localparam int CW = $clog2(L + 1),
  localparam int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   op,
  input  logic [N*B-1:0] wdata,
  input  logic           flush,
  output logic [N-1:0]   ack,
  output logic           err,
  output logic [B-1:0]   rdata,
  output logic           st_push,
  output logic           st_pop,
  output logic           st_clr,
  output logic [B-1:0]   st_wdata,
  input  logic [B-1:0]   st_rdata,
  output logic [CW-1:0]  count,
  output logic           full,
  output logic           empty,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] FULL_C = CW'(L);
  localparam logic [GW-1:0] LAST_RST_C = GW'(N - 1);

  state_t         state_r, state_s;
  logic [GW-1:0]  g_r, g_s;
  logic           op_r, op_s;
  logic [B-1:0]   wd_r, wd_s;
  logic           rej_r, rej_s;
  logic [GW-1:0]  last_r, last_s;
  logic [CW-1:0]  count_r, count_s;
  logic [N-1:0]   ack_r, ack_s;
  logic           err_r, err_s;
  logic [B-1:0]   rdata_r, rdata_s;
  logic           push_r, push_s;
  logic           pop_r, pop_s;
  logic           clr_r, clr_s;
  logic [B-1:0]   stw_r, stw_s;
  logic           found_s;
  logic [GW-1:0]  pick_s;
  logic           full_s;
  logic           empty_s;

  assign full_s  = (count_r == FULL_C);
  assign empty_s = (count_r == ZERO_C);

  // Round-robin pick: first requester above last_grant, wrapping mod N.
  always_comb begin
    found_s = 1'b0;
    pick_s  = last_r;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_r) + k) % N;
      if (!found_s && req[idx]) begin
        found_s = 1'b1;
        pick_s  = GW'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s = state_r;
    g_s     = g_r;
    op_s    = op_r;
    wd_s    = wd_r;
    rej_s   = rej_r;
    last_s  = last_r;
    count_s = count_r;
    rdata_s = rdata_r;
    ack_s   = {N{1'b0}};
    err_s   = 1'b0;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    clr_s   = 1'b0;
    stw_s   = {B{1'b0}};
    case (state_r)
      IDLE: begin
        // Flush wins over any pending request.
        if (flush) begin
          clr_s   = 1'b1;
          count_s = ZERO_C;
        end else if (found_s) begin
          g_s     = pick_s;
          op_s    = op[pick_s];
          wd_s    = wdata[int'(pick_s)*B +: B];
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if ((!op_r && full_s) || (op_r && empty_s)) begin
          rej_s   = 1'b1;
          state_s = DONE;
        end else if (!op_r) begin
          push_s  = 1'b1;
          stw_s   = wd_r;
          count_s = count_r + ONE_C;
          state_s = DONE;
        end else begin
          pop_s   = 1'b1;
          count_s = count_r - ONE_C;
          state_s = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // The stack presents the popped word while the pop strobe is out.
        rdata_s = st_rdata;
        state_s = DONE;
      end
      DONE: begin
        ack_s[g_r] = 1'b1;
        err_s      = rej_r;
        last_s     = g_r;
        rej_s      = 1'b0;
        state_s    = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      g_r     <= {GW{1'b0}};
      op_r    <= 1'b0;
      wd_r    <= {B{1'b0}};
      rej_r   <= 1'b0;
      last_r  <= LAST_RST_C;
      count_r <= ZERO_C;
      rdata_r <= {B{1'b0}};
      ack_r   <= {N{1'b0}};
      err_r   <= 1'b0;
      push_r  <= 1'b0;
      pop_r   <= 1'b0;
      clr_r   <= 1'b0;
      stw_r   <= {B{1'b0}};
    end else begin
      state_r <= state_s;
      g_r     <= g_s;
      op_r    <= op_s;
      wd_r    <= wd_s;
      rej_r   <= rej_s;
      last_r  <= last_s;
      count_r <= count_s;
      rdata_r <= rdata_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      push_r  <= push_s;
      pop_r   <= pop_s;
      clr_r   <= clr_s;
      stw_r   <= stw_s;
    end
  end

  assign ack      = ack_r;
  assign err      = err_r;
  assign rdata    = rdata_r;
  assign st_push  = push_r;
  assign st_pop   = pop_r;
  assign st_clr   = clr_r;
  assign st_wdata = stw_r;
  assign count    = count_r;
  assign full     = full_s;
  assign empty    = empty_s;
  assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed testbench for stack_arbiter (B=13, L=8, N=2) with a small
// behavioural LIFO attached to the stack-side interface.
module tb_stack_arbiter;

  localparam int B = 13;
  localparam int L = 8;
  localparam int N = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   op;
  logic [N*B-1:0] wdata;
  logic           flush;
  logic [N-1:0]   ack;
  logic           err;
  logic [B-1:0]   rdata;
  logic           st_push;
  logic           st_pop;
  logic           st_clr;
  logic [B-1:0]   st_wdata;
  logic [B-1:0]   st_rdata;
  logic [3:0]     count;
  logic           full;
  logic           empty;
  logic           busy;

  int checks = 0;
  int errors = 0;

  stack_arbiter #(.B(B), .L(L), .N(N)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
    .flush(flush), .ack(ack), .err(err), .rdata(rdata),
    .st_push(st_push), .st_pop(st_pop), .st_clr(st_clr),
    .st_wdata(st_wdata), .st_rdata(st_rdata), .count(count),
    .full(full), .empty(empty), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural LIFO: top-of-stack shown combinationally, updated on strobes.
  logic [B-1:0] mem [0:L-1];
  int sp;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0;
    end else if (st_clr) begin
      sp <= 0;
    end else if (st_push) begin
      if (sp < L) mem[sp] <= st_wdata;
      sp <= sp + 1;
    end else if (st_pop) begin
      sp <= sp - 1;
    end
  end
  assign st_rdata = (sp > 0 && sp <= L) ? mem[sp-1] : 13'h0000;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete request from requester r; checks ack, err, latency, strobes, data.
  task automatic do_op(input int r, input logic o, input logic [B-1:0] d,
                       input logic exp_err, input logic [B-1:0] exp_rd);
    int n;
    int pushes;
    int pops;
    logic got;
    logic [N-1:0] ack_v;
    logic err_v;
    logic [B-1:0] rd_v;
    logic [B-1:0] wd_v;
    logic [N-1:0] exp_ack;
    req[r] = 1'b1;
    op[r]  = o;
    wdata[r*B +: B] = d;
    n = 0; pushes = 0; pops = 0; got = 1'b0;
    ack_v = 2'b00; err_v = 1'b0; rd_v = 13'h0000; wd_v = 13'h0000;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (st_push) begin pushes++; wd_v = st_wdata; end
      if (st_pop) pops++;
      if (ack != 2'b00) begin
        got = 1'b1; ack_v = ack; err_v = err; rd_v = rdata;
      end
    end
    req[r] = 1'b0;
    exp_ack = 2'b01 << r;
    check_value("ack_seen", 32'(got), 32'd1);
    check_value("ack_vec", 32'(ack_v), 32'(exp_ack));
    check_value("err", 32'(err_v), 32'(exp_err));
    check_value("latency", n - 1, (exp_err || !o) ? 2 : 3);
    check_value("push_cnt", pushes, (!o && !exp_err) ? 1 : 0);
    check_value("pop_cnt", pops, (o && !exp_err) ? 1 : 0);
    if (!o && !exp_err) check_value("st_wdata", 32'(wd_v), 32'(d));
    if (o) check_value("rdata", 32'(rd_v), 32'(exp_rd));
  endtask

  initial begin
    int n;
    int acks;
    logic [N-1:0] seq [0:3];
    logic got;
    reset = 1'b1;
    req   = 2'b00;
    op    = 2'b00;
    wdata = 26'h0;
    flush = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check_value("rst_ack", 32'(ack), 32'd0);
    check_value("rst_err", 32'(err), 32'd0);
    check_value("rst_rdata", 32'(rdata), 32'd0);
    check_value("rst_strobes", 32'({st_push, st_pop, st_clr}), 32'd0);
    check_value("rst_st_wdata", 32'(st_wdata), 32'd0);
    check_value("rst_count", 32'(count), 32'd0);
    check_value("rst_flags", 32'({busy, empty, full}), 32'b010);
    reset = 1'b0;
    @(negedge clk);

    // Single push from requester 0
    do_op(0, 1'b0, 13'h0AA, 1'b0, 13'h0000);
    check_value("count_after_push", 32'(count), 32'd1);
    check_value("empty_after_push", 32'(empty), 32'd0);

    // Flush in IDLE: one clear pulse, count back to 0
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_value("flush_clr", 32'(st_clr), 32'd1);
    check_value("flush_count", 32'(count), 32'd0);
    @(negedge clk);
    check_value("flush_clr_pulse", 32'(st_clr), 32'd0);

    // Requester 1 fills the stack, then a rejected ninth push
    for (int i = 1; i <= 8; i++) begin
      do_op(1, 1'b0, 13'(i), 1'b0, 13'h0000);
      check_value("fill_count", 32'(count), 32'(i));
    end
    check_value("full_set", 32'(full), 32'd1);
    do_op(1, 1'b0, 13'h1FF, 1'b1, 13'h0000);
    check_value("full_reject_count", 32'(count), 32'd8);

    // Eight pops by requester 0 return 8..1, then a rejected pop by requester 1
    for (int i = 8; i >= 1; i--) begin
      do_op(0, 1'b1, 13'h0000, 1'b0, 13'(i));
      check_value("drain_count", 32'(count), 32'(i - 1));
    end
    do_op(1, 1'b1, 13'h0000, 1'b1, 13'h0001);
    check_value("empty_set", 32'(empty), 32'd1);
    check_value("empty_count", 32'(count), 32'd0);

    // Both requesters push continuously: grants alternate 0,1,0,1
    @(negedge clk);
    op    = 2'b00;
    wdata = {13'h0222, 13'h0111};
    req   = 2'b11;
    acks = 0; n = 0;
    while (acks < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (ack != 2'b00) begin
        check_value("rr_onehot", 32'($countones(ack)), 32'd1);
        seq[acks] = ack;
        acks++;
        if (acks == 4) req = 2'b00;
      end
    end
    check_value("rr_acks", acks, 4);
    check_value("rr_g0", 32'(seq[0]), 32'b01);
    check_value("rr_g1", 32'(seq[1]), 32'b10);
    check_value("rr_g2", 32'(seq[2]), 32'b01);
    check_value("rr_g3", 32'(seq[3]), 32'b10);
    check_value("rr_count", 32'(count), 32'd4);

    // Flush raised while a pop waits for data: pop completes, then clear
    @(negedge clk);
    req[0] = 1'b1;
    op[0]  = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (st_pop) flush = 1'b1;
      if (ack != 2'b00) begin
        got = 1'b1;
        check_value("fl_pop_ack", 32'(ack), 32'b01);
        check_value("fl_pop_err", 32'(err), 32'd0);
        check_value("fl_pop_rdata", 32'(rdata), 32'h0222);
        check_value("fl_no_early_clr", 32'(st_clr), 32'd0);
      end
    end
    req[0] = 1'b0;
    check_value("fl_pop_seen", 32'(got), 32'd1);
    check_value("fl_pop_latency", n - 1, 3);
    @(negedge clk);
    flush = 1'b0;
    check_value("fl_clr", 32'(st_clr), 32'd1);
    check_value("fl_count", 32'(count), 32'd0);
    check_value("fl_no_ack", 32'(ack), 32'd0);

    // Reset in the middle of a push while st_push is high
    @(negedge clk);
    req[0] = 1'b1;
    op[0]  = 1'b0;
    wdata[12:0] = 13'h0155;
    got = 1'b0; n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (st_push) got = 1'b1;
    end
    check_value("mid_push_seen", 32'(got), 32'd1);
    reset = 1'b1;
    #1;
    check_value("mid_rst_push", 32'(st_push), 32'd0);
    check_value("mid_rst_ack", 32'(ack), 32'd0);
    check_value("mid_rst_count", 32'(count), 32'd0);
    check_value("mid_rst_flags", 32'({busy, empty, full}), 32'b010);
    req = 2'b00;
    acks = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack != 2'b00) acks++;
    end
    check_value("mid_rst_no_ack", acks, 0);
    check_value("mid_rst_count_after", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
